// File: rtl/mul_hilo_unit_pkg.sv
// mul_hilo_unit_pkg
//   Shared types for the HI/LO multiply sequencer.
//   - op_e       : EX op codes accepted by the unit (3 bits, all codes defined)
//   - state_e    : sequencer states
//   - acc_mode_e : operation selected inside hilo_acc
//   Helpers decode signedness, multiplier use and accumulate mode from an op.
//   Optional feature macro: MUL_HILO_MADD_EN (consumed by the top, not here).
package mul_hilo_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MTHI  = 3'd2,
    OP_MTLO  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACC_PASS = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_mode_e;

  // MULT/MADD/MSUB treat operands as two's complement.
  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // True when the op needs a trip through the multiplier.
  function automatic logic is_mul_op(input op_e op, input logic madd_en);
    logic plain_mul;
    logic acc_mul;
    plain_mul = (op == OP_MULT) || (op == OP_MULTU);
    acc_mul   = (op == OP_MADD) || (op == OP_MADDU) ||
                (op == OP_MSUB) || (op == OP_MSUBU);
    return plain_mul || (madd_en && acc_mul);
  endfunction

  function automatic acc_mode_e acc_mode_of(input op_e op);
    acc_mode_e m;
    m = ACC_PASS;
    if ((op == OP_MADD) || (op == OP_MADDU)) m = ACC_ADD;
    if ((op == OP_MSUB) || (op == OP_MSUBU)) m = ACC_SUB;
    return m;
  endfunction

endpackage

// File: rtl/mul_hilo_unit_if.sv
// mul_hilo_unit_if
//   EX -> multiply unit request handshake.
//   req_valid (EX->unit)  op presented
//   req_ready (unit->EX)  unit idle and able to accept
//   req_op    (EX->unit)  op code
//   req_a     (EX->unit)  rs operand, also MTHI/MTLO data
//   req_b     (EX->unit)  rt operand
//   master: EX stage side.  slave: mul_hilo_unit side.
interface mul_hilo_unit_if;
  import mul_hilo_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  op_e         req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    output req_ready
  );

endinterface

// File: rtl/mul_hilo_unit_hilo_acc.sv
// hilo_acc
//   64-bit pass / add / subtract of the current {hi,lo} and the product.
//   Results wrap modulo 2^64; there is no overflow indication.
//   acc_in   in  64  current {hi,lo}
//   prod     in  64  multiplier product
//   mode     in  2   ACC_PASS / ACC_ADD / ACC_SUB
//   acc_out  out 64  new {hi,lo}
//   Only compiled when MUL_HILO_MADD_EN is defined.
`ifdef MUL_HILO_MADD_EN
module hilo_acc
  import mul_hilo_unit_pkg::*;
(
  input  logic [63:0] acc_in,
  input  logic [63:0] prod,
  input  acc_mode_e   mode,
  output logic [63:0] acc_out
);

  always_comb begin
    acc_out = prod;
    unique case (mode)
      ACC_ADD:  acc_out = acc_in + prod;
      ACC_SUB:  acc_out = acc_in - prod;
      default:  acc_out = prod;
    endcase
  end

endmodule
`endif

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit
//   Sequencer between EX and an external pipelined multiplier. Holds operands
//   on mul_x/mul_y for the multiplier latency, then commits the product to
//   HI/LO. MTHI/MTLO and ops without a multiply complete from IDLE in one cycle.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req (slave)         EX handshake: valid/ready/op/a/b
//     flush               aborts an in-flight op, blocks acceptance
//     mul_x, mul_y        registered operands to the multiplier
//     mul_signed          1 for signed ops
//     mul_result          64-bit product, valid in CAPT
//     hi, lo              architectural HI/LO
//     busy                ~req_ready
//     done                1-cycle pulse with each HI/LO commit or no-op accept
//   Optional feature macro: MUL_HILO_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
//
//   state  | meaning
//   S_IDLE | ready; MTHI/MTLO/no-op retire here, multiplies launch
//   S_WAIT | operands held, cnt counts down the multiplier latency
//   S_CAPT | mul_result valid, commit to HI/LO on the next edge
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mul_hilo_unit_if.slave        req,
  input  logic                  flush,
  output logic [31:0]           mul_x,
  output logic [31:0]           mul_y,
  output logic                  mul_signed,
  input  logic [63:0]           mul_result,
  output logic [31:0]           hi,
  output logic [31:0]           lo,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);

`ifdef MUL_HILO_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic             signed_q, signed_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic             accept;
  logic [63:0]      capt_val;

`ifdef MUL_HILO_MADD_EN
  hilo_acc u_hilo_acc (
    .acc_in  ({hi_q, lo_q}),
    .prod    (mul_result),
    .mode    (acc_mode_of(op_q)),
    .acc_out (capt_val)
  );
`else
  // Only MULT/MULTU ever reach CAPT here; anything else leaves HI/LO alone.
  assign capt_val = ((op_q == OP_MULT) || (op_q == OP_MULTU)) ? mul_result
                                                               : {hi_q, lo_q};
`endif

  assign accept = req.req_valid & (state_q == S_IDLE) & ~flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    signed_d = signed_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op(req.req_op, MADD_EN)) begin
            x_d      = req.req_a;
            y_d      = req.req_b;
            signed_d = is_signed_op(req.req_op);
            op_d     = req.req_op;
            cnt_d    = CNT_W'(MUL_LATENCY);
            state_d  = S_WAIT;
          end else begin
            // MTHI/MTLO and unsupported codes retire immediately.
            done_d = 1'b1;
            if (req.req_op == OP_MTHI) hi_d = req.req_a;
            if (req.req_op == OP_MTLO) lo_d = req.req_a;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        state_d = S_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = capt_val;
          done_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      x_q      <= '0;
      y_q      <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign req.req_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign mul_x         = x_q;
  assign mul_y         = y_q;
  assign mul_signed    = signed_q;
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb_mul_hilo_unit
//   Directed bench for mul_hilo_unit with a one-stage behavioural multiplier
//   (mul_clk = clk, resetn = ~reset). Optional path: MUL_HILO_MADD_EN.
module tb_mul_hilo_unit;
  import mul_hilo_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] mul_x, mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic [31:0] hi, lo;
  logic        busy, done;
  logic        resetn;

  int n_tests = 0;
  int n_fail  = 0;

  mul_hilo_unit_if req_if ();

  mul_hilo_unit #(.MUL_LATENCY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req_if.slave),
    .flush      (flush),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  // One register stage multiplier; truncated product of extended operands.
  assign resetn = ~reset;
  logic [63:0] ext_x, ext_y;
  assign ext_x = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'b0, mul_x};
  assign ext_y = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'b0, mul_y};
  always_ff @(posedge clk) begin
    if (!resetn) mul_result <= '0;
    else         mul_result <= ext_x * ext_y;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input op_e op, input logic [31:0] a, input logic [31:0] b);
    req_if.req_valid = v;
    req_if.req_op    = op;
    req_if.req_a     = a;
    req_if.req_b     = b;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_hi",    hi, 32'h0);
    check("rst_lo",    lo, 32'h0);
    check("rst_done",  done, 1'b0);
    check("rst_ready", req_if.req_ready, 1'b1);
    check("rst_busy",  busy, 1'b0);
    check("rst_mulx",  mul_x, 32'h0);

    // 1: MULT -2 * 3
    drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'h3);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    check("t1_ready_c1", req_if.req_ready, 1'b0);
    check("t1_busy_c1",  busy, 1'b1);
    check("t1_mulx",     mul_x, 32'hFFFF_FFFE);
    check("t1_muly",     mul_y, 32'h3);
    check("t1_signed",   mul_signed, 1'b1);
    check("t1_done_c1",  done, 1'b0);
    tick();
    check("t1_ready_c2", req_if.req_ready, 1'b0);
    check("t1_done_c2",  done, 1'b0);
    check("t1_mulx_hold", mul_x, 32'hFFFF_FFFE);
    check("t1_hi_c2",    hi, 32'h0);
    tick();
    check("t1_hi",       hi, 32'hFFFF_FFFF);
    check("t1_lo",       lo, 32'hFFFF_FFFA);
    check("t1_done",     done, 1'b1);
    check("t1_ready",    req_if.req_ready, 1'b1);
    tick();
    check("t1_done_off", done, 1'b0);

    // 2: MULTU 0xFFFFFFFF^2
    drive(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    check("t2_signed", mul_signed, 1'b0);
    tick();
    tick();
    check("t2_hi",   hi, 32'hFFFF_FFFE);
    check("t2_lo",   lo, 32'h0000_0001);
    check("t2_done", done, 1'b1);

    // 3: MTHI then MTLO back-to-back, starting in the done cycle
    drive(1'b1, OP_MTHI, 32'h1234_5678, 32'h0);
    tick();
    check("t3_hi",      hi, 32'h1234_5678);
    check("t3_lo_keep", lo, 32'h0000_0001);
    check("t3_done1",   done, 1'b1);
    check("t3_ready1",  req_if.req_ready, 1'b1);
    drive(1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    check("t3_lo",      lo, 32'h9ABC_DEF0);
    check("t3_hi_keep", hi, 32'h1234_5678);
    check("t3_done2",   done, 1'b1);
    tick();
    check("t3_done_off", done, 1'b0);

    // 4: MULT 5*7 flushed in WAIT
    drive(1'b1, OP_MULT, 32'h5, 32'h7);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    check("t4_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_ready", req_if.req_ready, 1'b1);
    check("t4_done",  done, 1'b0);
    tick();
    check("t4_done2", done, 1'b0);
    check("t4_hi",    hi, 32'h1234_5678);
    check("t4_lo",    lo, 32'h9ABC_DEF0);

    // flush alongside a request in IDLE: request dropped
    drive(1'b1, OP_MTHI, 32'h0000_DEAD, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    check("fl_idle_hi",   hi, 32'h1234_5678);
    check("fl_idle_done", done, 1'b0);

`ifndef MUL_HILO_MADD_EN
    // op code 6 without the accumulate feature: no-op with done
    drive(1'b1, OP_MSUB, 32'h55, 32'h66);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    check("unl_done",  done, 1'b1);
    check("unl_ready", req_if.req_ready, 1'b1);
    check("unl_hi",    hi, 32'h1234_5678);
    check("unl_lo",    lo, 32'h9ABC_DEF0);
    tick();
`endif

    // 5: reset during WAIT
    drive(1'b1, OP_MULT, 32'h3, 32'h3);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_hi",    hi, 32'h0);
    check("t5_lo",    lo, 32'h0);
    check("t5_done",  done, 1'b0);
    check("t5_ready", req_if.req_ready, 1'b1);
    check("t5_mulx",  mul_x, 32'h0);
    tick();
    check("t5_done2", done, 1'b0);
    drive(1'b1, OP_MULT, 32'h2, 32'h2);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    tick();
    tick();
    check("t5_mul_lo",   lo, 32'h4);
    check("t5_mul_hi",   hi, 32'h0);
    check("t5_mul_done", done, 1'b1);

`ifdef MUL_HILO_MADD_EN
    // 6: hi:lo = 0:10, MSUB 3*4, then MADDU 1*2
    drive(1'b1, OP_MTLO, 32'd10, 32'h0);
    tick();
    drive(1'b1, OP_MSUB, 32'd3, 32'd4);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    tick();
    tick();
    check("t6_msub_hi", hi, 32'hFFFF_FFFF);
    check("t6_msub_lo", lo, 32'hFFFF_FFFE);
    drive(1'b1, OP_MADDU, 32'd1, 32'd2);
    tick();
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    check("t6_maddu_signed", mul_signed, 1'b0);
    tick();
    tick();
    check("t6_madd_hi",   hi, 32'h0);
    check("t6_madd_lo",   lo, 32'h0);
    check("t6_madd_done", done, 1'b1);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
